// File: rtl/maxheap_pkg.sv
`default_nettype none
// maxheap_pkg: shared widths, element type and drain FSM states for the maxheap family.
package maxheap_pkg;

  localparam int DEF_DATA_WIDTH = 10;
  localparam int DEF_PRIO_WIDTH = 32;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_PRIO_WIDTH-1:0] prio;
  } heap_elem_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/prio_fifo.sv
`default_nettype none
// prio_fifo: circular-buffer FIFO of heap elements with occupancy count and async reset.
module prio_fifo
  import maxheap_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type elem_t = heap_elem_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  elem_t                  wr_elem,
  input  logic                   rd_en,
  output elem_t                  rd_elem,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  elem_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_elem = mem[rd_ptr];

  // Storage is cleared on reset so the head output is never X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_elem;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/heap_drain.sv
`default_nettype none
// heap_drain: pops the heap maximum, forwards elements at/above threshold through a FIFO,
// and counts (saturating) the ones below it.
module heap_drain
  import maxheap_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PRIO_WIDTH = DEF_PRIO_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  sink_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PRIO_WIDTH-1:0] threshold,
  input  logic                  heap_valid,
  input  logic [DATA_WIDTH-1:0] heap_data,
  input  logic [PRIO_WIDTH-1:0] heap_prio,
  output logic                  heap_pop,
  output logic                  source_valid,
  input  logic                  source_ready,
  output logic [DATA_WIDTH-1:0] source_data,
  output logic [PRIO_WIDTH-1:0] source_prio,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [PRIO_WIDTH-1:0] prio;
  } elem_t;

  drain_state_t  state;
  drain_state_t  next_state;
  logic          pop_next;
  logic          room;
  logic          capture;
  logic          pass;
  logic          fifo_wr;
  logic          fifo_rd;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  elem_t         wr_elem;
  elem_t         rd_elem;

  // Room is only needed in IDLE: with a single element in flight the capture cannot overflow.
  assign room    = (fifo_count < CW'(FIFO_DEPTH));
  assign capture = (state == POP) && heap_valid;
  assign pass    = ($signed(heap_prio) >= $signed(threshold));
  assign fifo_wr = capture && pass && !fifo_full;
  assign fifo_rd = source_valid && source_ready;
  assign wr_elem = '{data: heap_data, prio: heap_prio};

  always_ff @(posedge sink_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      heap_pop <= 1'b0;
    end else begin
      state    <= next_state;
      heap_pop <= pop_next;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable && heap_valid && room) next_state = POP;
      POP:     next_state = SETTLE;
      SETTLE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    pop_next = (next_state == POP);
  end

  always_ff @(posedge sink_clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (capture && !pass && (drop_count != {CNT_WIDTH{1'b1}})) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  prio_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .elem_t (elem_t)
  ) u_fifo (
    .clk     (sink_clk),
    .rst     (reset),
    .wr_en   (fifo_wr),
    .wr_elem (wr_elem),
    .rd_en   (fifo_rd),
    .rd_elem (rd_elem),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign source_valid = !fifo_empty;
  assign source_data  = rd_elem.data;
  assign source_prio  = rd_elem.prio;

endmodule
`default_nettype wire

// File: tb/tb_heap_drain.sv
`default_nettype none
// tb_heap_drain: randomized and directed checks of heap_drain against a queue-based model.
`timescale 1ns/1ps
module tb_heap_drain;

  localparam int DW    = 10;
  localparam int PW    = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [DW-1:0] d;
    int            p;
  } item_t;

  logic          sink_clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          source_ready;
  logic [PW-1:0] threshold;
  logic          heap_valid;
  logic [DW-1:0] heap_data;
  logic [PW-1:0] heap_prio;
  logic          heap_pop;
  logic          source_valid;
  logic [DW-1:0] source_data;
  logic [PW-1:0] source_prio;
  logic [15:0]   drop_count;
  logic          sat_pop;
  logic          sat_valid;
  logic [DW-1:0] sat_data;
  logic [PW-1:0] sat_prio;
  logic [3:0]    sat_drop;

  int errors = 0;
  int checks = 0;

  heap_drain #(.DATA_WIDTH(DW), .PRIO_WIDTH(PW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .sink_clk(sink_clk), .reset(reset), .enable(enable), .threshold(threshold),
    .heap_valid(heap_valid), .heap_data(heap_data), .heap_prio(heap_prio),
    .heap_pop(heap_pop), .source_valid(source_valid), .source_ready(source_ready),
    .source_data(source_data), .source_prio(source_prio), .drop_count(drop_count)
  );

  heap_drain #(.DATA_WIDTH(DW), .PRIO_WIDTH(PW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(4)) dut_sat (
    .sink_clk(sink_clk), .reset(reset), .enable(enable), .threshold(threshold),
    .heap_valid(heap_valid), .heap_data(heap_data), .heap_prio(heap_prio),
    .heap_pop(sat_pop), .source_valid(sat_valid), .source_ready(source_ready),
    .source_data(sat_data), .source_prio(sat_prio), .drop_count(sat_drop)
  );

  always #5 sink_clk = ~sink_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Heap model: the max element is presented, removed on a pop edge while valid.
  item_t  heap_q[$];
  item_t  ins_q[$];
  int     ins_rd = 0;
  logic   hv_r;
  logic   [DW-1:0] hd_r;
  logic   [PW-1:0] hp_r;
  int     hidx_r;
  logic   kill = 1'b0;

  assign heap_valid = hv_r && !kill;
  assign heap_data  = hd_r;
  assign heap_prio  = hp_r;

  always @(posedge sink_clk or posedge reset) begin
    int best;
    if (reset) begin
      heap_q.delete();
      ins_rd = ins_q.size();
      hv_r   <= 1'b0;
      hd_r   <= '0;
      hp_r   <= '0;
      hidx_r <= 0;
    end else begin
      if (heap_pop && heap_valid) heap_q.delete(hidx_r);
      while (ins_rd < ins_q.size()) begin
        heap_q.push_back(ins_q[ins_rd]);
        ins_rd++;
      end
      best = -1;
      foreach (heap_q[i]) if (best < 0 || heap_q[i].p > heap_q[best].p) best = i;
      hv_r   <= (best >= 0);
      hidx_r <= (best < 0) ? 0 : best;
      if (best >= 0) begin
        hd_r <= heap_q[best].d;
        hp_r <= heap_q[best].p;
      end
    end
  end

  // Drain reference: pop edges with a valid head either forward or drop the element.
  item_t exp_q[$];
  int    drops = 0;
  int    pops  = 0;
  int    fwd   = 0;
  int    cyc   = 0;
  int    last_pop = -100;

  always @(posedge sink_clk or posedge reset) begin
    item_t it;
    if (reset) begin
      exp_q.delete();
      drops = 0;
      pops  = 0;
    end else begin
      cyc++;
      if (source_valid && source_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        fwd++;
      end
      if (heap_pop) begin
        pops++;
        if (heap_valid) begin
          if ($signed(heap_prio) >= $signed(threshold)) begin
            it.d = heap_data;
            it.p = heap_prio;
            exp_q.push_back(it);
          end else begin
            drops++;
          end
        end
      end
    end
  end

  always @(negedge sink_clk) begin
    if (!reset) begin
      chk("src_valid", source_valid, exp_q.size() != 0);
      chk("sat_valid", sat_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("src_data", source_data, exp_q[0].d);
        chk("src_prio", source_prio, $unsigned(exp_q[0].p));
        chk("sat_data", sat_data, exp_q[0].d);
        chk("sat_prio", sat_prio, $unsigned(exp_q[0].p));
      end
      chk("drop_count", drop_count, drops);
      chk("sat_drop", sat_drop, (drops > 15) ? 15 : drops);
      chk("sat_pop", sat_pop, heap_pop);
      if (heap_pop) begin
        chk("pop_room", exp_q.size() < DEPTH, 1);
        chk("pop_spacing", (cyc - last_pop) >= 3, 1);
        last_pop = cyc;
      end
    end else begin
      last_pop = -100;
    end
  end

  task automatic ins(input int d, input int p);
    item_t it;
    it.d = d[DW-1:0];
    it.p = p;
    ins_q.push_back(it);
  endtask

  task automatic wait_pop(input int lim);
    int n = 0;
    do begin
      @(negedge sink_clk);
      n++;
    end while (!heap_pop && n < lim);
    chk("pop_wait", heap_pop, 1);
  endtask

  task automatic drain(input int lim);
    int   n = 0;
    logic done;
    do begin
      @(negedge sink_clk);
      n++;
      done = (heap_q.size() == 0) && (ins_rd == ins_q.size()) && (exp_q.size() == 0)
             && !source_valid && !heap_pop;
    end while (!done && n < lim);
    chk("drain_done", done, 1);
  endtask

  initial begin
    int t0, t1, t2, t3, d0, f0, p0, rp;
    reset = 1'b1; enable = 1'b0; source_ready = 1'b0; threshold = '0;
    repeat (3) @(posedge sink_clk);
    @(negedge sink_clk);
    reset = 1'b0;
    chk("rst_pop", heap_pop, 0);
    chk("rst_valid", source_valid, 0);
    chk("rst_data", source_data, 0);
    chk("rst_prio", source_prio, 0);
    chk("rst_drop", drop_count, 0);
    repeat (4) @(negedge sink_clk) chk("empty_nopop", heap_pop, 0);

    // Latency from heap_valid rising with an empty FIFO.
    enable = 1'b1;
    ins(7, 20);
    @(negedge sink_clk);
    chk("lat_hv", heap_valid, 1);
    chk("lat_n_pop", heap_pop, 0);
    @(negedge sink_clk);
    chk("lat_n1_pop", heap_pop, 1);
    @(negedge sink_clk);
    chk("lat_n2_valid", source_valid, 1);
    source_ready = 1'b1;
    drain(20);

    // Filter with inserts between pops; pops must be exactly 3 cycles apart.
    threshold = 60; d0 = drops; f0 = fwd;
    ins(1, 90);
    wait_pop(10); t0 = cyc; ins(2, 70);
    wait_pop(10); t1 = cyc; ins(3, 50);
    wait_pop(10); t2 = cyc; ins(4, 95);
    wait_pop(10); t3 = cyc;
    chk("gap01", t1 - t0, 3);
    chk("gap12", t2 - t1, 3);
    chk("gap23", t3 - t2, 3);
    drain(30);
    chk("filter_drop", drops - d0, 1);
    chk("filter_fwd", fwd - f0, 3);

    // Signed threshold.
    threshold = -5; d0 = drops; f0 = fwd;
    ins(11, -3); ins(12, -10); ins(13, -5);
    drain(40);
    chk("signed_drop", drops - d0, 1);
    chk("signed_fwd", fwd - f0, 2);
    chk("signed_cnt", drop_count, drops);

    // Backpressure: FIFO fills, popping stops, then resumes.
    threshold = 0; source_ready = 1'b0; p0 = pops; f0 = fwd;
    for (int i = 0; i < 6; i++) ins(20 + i, 100 + i);
    repeat (40) @(negedge sink_clk);
    chk("bp_pops", pops - p0, 4);
    repeat (5) @(negedge sink_clk) chk("bp_nopop", heap_pop, 0);
    source_ready = 1'b1;
    drain(60);
    chk("bp_pops_all", pops - p0, 6);
    chk("bp_fwd", fwd - f0, 6);

    // Abort: heap_valid drops during POP.
    source_ready = 1'b0; d0 = drops;
    ins(30, 40);
    wait_pop(10);
    kill = 1'b1;
    @(negedge sink_clk);
    chk("abort_nowrite", source_valid, 0);
    chk("abort_drop", drop_count, d0);
    repeat (3) @(negedge sink_clk) chk("abort_idle", heap_pop, 0);
    kill = 1'b0;
    f0 = fwd;
    source_ready = 1'b1;
    drain(20);
    chk("abort_refwd", fwd - f0, 1);

    // Asynchronous reset mid-POP with a partly filled FIFO.
    source_ready = 1'b0;
    for (int i = 0; i < 5; i++) ins(40 + i, 200 + i);
    for (int i = 0; i < 4; i++) wait_pop(10);
    #1 reset = 1'b1;
    #1;
    chk("arst_pop", heap_pop, 0);
    chk("arst_valid", source_valid, 0);
    chk("arst_drop", drop_count, 0);
    chk("arst_data", source_data, 0);
    chk("arst_prio", source_prio, 0);
    @(negedge sink_clk);
    reset = 1'b0;
    repeat (5) @(negedge sink_clk) chk("arst_nopop", heap_pop, 0);

    // Saturation on the narrow counter.
    source_ready = 1'b1; threshold = 1000;
    for (int i = 0; i < 17; i++) ins(50 + i, i * 7);
    drain(100);
    chk("sat_15", sat_drop, 15);
    chk("wide_17", drop_count, 17);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      @(negedge sink_clk);
      enable       = ($urandom % 8) != 0;
      source_ready = ($urandom % 3) != 0;
      if (($urandom % 4) == 0) begin
        rp = int'($urandom_range(400)) - 200;
        ins(int'($urandom_range(1023)), rp);
      end
      if (($urandom % 50) == 0) threshold = int'($urandom_range(200)) - 100;
    end
    enable = 1'b1; source_ready = 1'b1;
    drain(2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/heap_drain.md
Name: heap_drain

Overview:
- Downstream consumer of the maxheap priority queue.
- Pops the current maximum element whenever the heap is non-empty and there is room downstream.
- Filters popped elements against a programmable priority threshold: elements at or above it enter a small output FIFO, the rest are discarded and counted.
- Presents the forwarded stream on a valid/ready source interface.

Parameters:
- DATA_WIDTH, 10, payload width (matches maxheap).
- PRIO_WIDTH, 32, signed priority width (matches maxheap).
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.
- CNT_WIDTH, 16, width of the drop counter.

Ports:
- sink_clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  allows new pops when high.
- threshold  in  PRIO_WIDTH  signed minimum priority to forward.
- heap_valid  in  1  heap non-empty; heap_data/heap_prio show the current maximum.
- heap_data  in  DATA_WIDTH  payload of the current maximum.
- heap_prio  in  PRIO_WIDTH  signed priority of the current maximum.
- heap_pop  out  1  one-cycle pulse; the heap removes its maximum at the rising edge where this is high.
- source_valid  out  1  FIFO head valid.
- source_ready  in  1  downstream accepts the head.
- source_data  out  DATA_WIDTH  head payload.
- source_prio  out  PRIO_WIDTH  head priority.
- drop_count  out  CNT_WIDTH  number of elements discarded below threshold.

Behaviour:
- Clock and reset: one clock, sink_clk. reset is asynchronous and active-high.
- Reset values: state IDLE; heap_pop 0; FIFO empty; source_valid 0; source_data 0; source_prio 0; drop_count 0.
- Reset acts immediately when asserted, at any point, including mid-POP or with a full FIFO. FIFO contents are discarded.
- FSM IDLE:
  - Go to POP when enable && heap_valid && fifo_count < FIFO_DEPTH.
  - Otherwise stay in IDLE.
- FSM POP:
  - heap_pop = 1 (registered output, high only in this state).
  - At the closing edge, sample heap_valid/heap_data/heap_prio.
  - Always go to SETTLE.
- FSM SETTLE:
  - heap_pop = 0; one cycle for the heap to re-heapify.
  - Always go to IDLE.
- Cadence and latency:
  - Maximum pop rate is one every 3 cycles.
  - From heap_valid rising (FIFO empty, enable high): heap_pop is high in cycle n+1, and source_valid goes high in cycle n+2.
- Capture at the POP closing edge:
  - heap_valid = 0 (heap emptied or reset externally): no write, no count; the pop is aborted.
  - Otherwise, if $signed(heap_prio) >= $signed(threshold): write {data, prio} to the FIFO tail.
  - Otherwise: drop_count increments, saturating at all-ones.
- FIFO room:
  - Room is checked in IDLE only.
  - At most one element is in flight, and the FIFO never decreases occupancy except by reads, so the capture write can never overflow.
- FIFO operation:
  - Circular buffer with read/write pointers and an occupancy count of width clog2(FIFO_DEPTH)+1.
  - A read occurs when source_valid && source_ready.
  - A simultaneous read and write in the same cycle leaves occupancy unchanged; both take effect.
  - source_data/source_prio reflect the entry at the read pointer. They are don't-care while source_valid = 0, but must not be X after reset.
- Ordering: elements are forwarded in pop order. No reordering; no ordering check, since heap inserts may legally raise the maximum between pops.
- enable deasserted: takes effect only in IDLE; an in-progress POP/SETTLE completes normally.
- threshold: sampled only at the POP closing edge. Changing it does not affect elements already in the FIFO.

Decomposition:
- Shared package maxheap_pkg:
  - DATA_WIDTH/PRIO_WIDTH default constants.
  - heap element struct {data, prio}.
  - drain FSM state enum {IDLE, POP, SETTLE}.
- Sub-module prio_fifo: synchronous FIFO of element structs with wr_en, rd_en, full, empty, count, and asynchronous reset. heap_drain instantiates it once and holds the FSM, filter and counter.

Test Plan:
- Reset: assert reset mid-cycle -> heap_pop, source_valid, drop_count all 0 immediately; after release, no pop until heap_valid = 1.
- Filter: heap model presents prio 90, 70, 50, 95 (data 1..4) with inserts made between pops, threshold = 60, source_ready = 1 -> forwarded prio sequence matches pop order with 50 omitted; drop_count = 1; consecutive heap_pop pulses are exactly 3 cycles apart.
- Backpressure: source_ready = 0, heap holds 6 elements, all >= threshold, FIFO_DEPTH = 4 -> exactly 4 heap_pop pulses, then heap_pop stays 0. Raise source_ready -> 4 elements emerge in order, then the remaining 2 are popped and forwarded.
- Signed compare: threshold = -5; prio -3 -> forwarded; prio -10 -> dropped (drop_count = 1); prio -5 -> forwarded.
- Abort: heap_valid falls during POP -> no FIFO write and drop_count unchanged; FSM returns to IDLE after SETTLE.
- Saturation: with CNT_WIDTH = 4, drop 17 elements -> drop_count = 15.
